// File: rtl/morse_fm_sequencer_pkg.sv
// Shared definitions for the Morse FM keying sequencer: state codes, element timing
// in dot units, and symbol field widths.
package morse_pkg;

   localparam int unsigned MAX_ELEMENTS = 5;
   localparam int unsigned LEN_W        = 3;
   localparam int unsigned BITS_W       = 5;
   localparam int unsigned UNIT_W       = 3;

   // Sequencer states, kept as plain encoded constants
   typedef logic [2:0] state_t;
   localparam state_t StIdle    = 3'd0;
   localparam state_t StMark    = 3'd1;
   localparam state_t StElemGap = 3'd2;
   localparam state_t StCharGap = 3'd3;
   localparam state_t StWordGap = 3'd4;

   localparam logic [UNIT_W-1:0] DOT_UNITS      = 3'd1;
   localparam logic [UNIT_W-1:0] DASH_UNITS     = 3'd3;
   localparam logic [UNIT_W-1:0] ELEM_GAP_UNITS = 3'd1;
   localparam logic [UNIT_W-1:0] CHAR_GAP_UNITS = 3'd3;
   localparam logic [UNIT_W-1:0] WORD_GAP_UNITS = 3'd4;

   // Lengths 6 and 7 behave as the maximum element count
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len > LEN_W'(MAX_ELEMENTS)) ? LEN_W'(MAX_ELEMENTS) : len;
   endfunction

endpackage

// File: rtl/morse_fm_sequencer_if.sv
// Symbol handshake bus feeding the Morse sequencer.
interface morse_fm_sequencer_if;
   import morse_pkg::*;

   logic              symbol_valid;
   logic              symbol_ready;
   logic [LEN_W-1:0]  symbol_len;
   logic [BITS_W-1:0] symbol_bits;

   modport master (
      output symbol_valid,
      output symbol_len,
      output symbol_bits,
      input  symbol_ready
   );

   modport slave (
      input  symbol_valid,
      input  symbol_len,
      input  symbol_bits,
      output symbol_ready
   );

endinterface

// File: rtl/morse_fm_sequencer_phase_accumulator.sv
// Free-running phase accumulator with two selectable increments (FM keying).
module phase_accumulator #(
   parameter int unsigned         accBits   = 32,
   parameter int unsigned         phaseBits = 16,
   parameter logic [accBits-1:0]  spaceInc  = accBits'(32'h0100_0000),
   parameter logic [accBits-1:0]  markInc   = accBits'(32'h0110_0000)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 key,
   output logic [phaseBits-1:0] phase
);

   logic [accBits-1:0] acc_q, acc_d;

   // Advance every cycle, wrapping naturally modulo 2^accBits
   always_comb begin
      acc_d = acc_q + (key ? markInc : spaceInc);
   end

   // Accumulator register
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign phase = acc_q[accBits-1 -: phaseBits];

endmodule

// File: rtl/morse_fm_sequencer.sv
// Morse symbol sequencer: times marks and gaps in dot units and keys an FM phase
// accumulator between space and mark tones.
module morse_fm_sequencer
   import morse_pkg::*;
#(
   parameter int unsigned        accBits    = 32,
   parameter int unsigned        phaseBits  = 16,
   parameter int unsigned        unitCycles = 1200000,
   parameter logic [accBits-1:0] spaceInc   = accBits'(32'h0100_0000),
   parameter logic [accBits-1:0] markInc    = accBits'(32'h0110_0000)
) (
   input  logic                   clk,
   input  logic                   reset,
   morse_fm_sequencer_if.slave    sym,
   output logic [phaseBits-1:0]   phase,
   output logic                   key,
   output logic                   busy
);

   localparam int unsigned     CycW    = (unitCycles > 1) ? $clog2(unitCycles) : 1;
   localparam logic [CycW-1:0] CycLast = CycW'(unitCycles - 1);

   state_t              state_q, state_d;
   logic [CycW-1:0]     cyc_q, cyc_d;
   logic [UNIT_W-1:0]   unit_q, unit_d;   // remaining units minus one
   logic [LEN_W-1:0]    elem_q, elem_d;   // elements left, including the current one
   logic [BITS_W-1:0]   shift_q, shift_d; // bit 0 is the current element
   logic                key_q, key_d;
   logic                state_done;
   logic [LEN_W-1:0]    acc_len;

   assign state_done = (cyc_q == CycLast) && (unit_q == '0);
   assign acc_len    = clamp_len(sym.symbol_len);

   // Next-state, unit timer and element shift register
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      unit_d  = unit_q;
      elem_d  = elem_q;
      shift_d = shift_q;
      case (state_q)
         StIdle: begin
            if (sym.symbol_valid) begin
               shift_d = sym.symbol_bits;
               elem_d  = acc_len;
               cyc_d   = '0;
               if (acc_len == '0) begin
                  state_d = StWordGap;
                  unit_d  = WORD_GAP_UNITS - 3'd1;
               end else begin
                  state_d = StMark;
                  unit_d  = (sym.symbol_bits[0] ? DASH_UNITS : DOT_UNITS) - 3'd1;
               end
            end
         end
         StMark, StElemGap, StCharGap, StWordGap: begin
            if (!state_done) begin
               if (cyc_q == CycLast) begin
                  cyc_d  = '0;
                  unit_d = unit_q - 3'd1;
               end else begin
                  cyc_d = cyc_q + CycW'(1);
               end
            end else begin
               cyc_d = '0;
               if (state_q == StMark) begin
                  if (elem_q > 3'd1) begin
                     state_d = StElemGap;
                     unit_d  = ELEM_GAP_UNITS - 3'd1;
                     elem_d  = elem_q - 3'd1;
                     shift_d = shift_q >> 1;
                  end else begin
                     state_d = StCharGap;
                     unit_d  = CHAR_GAP_UNITS - 3'd1;
                  end
               end else if (state_q == StElemGap) begin
                  state_d = StMark;
                  unit_d  = (shift_q[0] ? DASH_UNITS : DOT_UNITS) - 3'd1;
               end else begin
                  state_d = StIdle;
                  unit_d  = '0;
               end
            end
         end
         default: begin
            state_d = StIdle;
            cyc_d   = '0;
            unit_d  = '0;
         end
      endcase
      // Key is registered alongside the state so it tracks the state exactly
      key_d = (state_d == StMark);
   end

   // Sequencer state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cyc_q   <= '0;
         unit_q  <= '0;
         elem_q  <= '0;
         shift_q <= '0;
         key_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         unit_q  <= unit_d;
         elem_q  <= elem_d;
         shift_q <= shift_d;
         key_q   <= key_d;
      end
   end

   assign sym.symbol_ready = (state_q == StIdle);
   assign busy             = (state_q != StIdle);
   assign key              = key_q;

   phase_accumulator #(
      .accBits   (accBits),
      .phaseBits (phaseBits),
      .spaceInc  (spaceInc),
      .markInc   (markInc)
   ) u_phase_acc (
      .clk   (clk),
      .reset (reset),
      .key   (key_q),
      .phase (phase)
   );

endmodule
